// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / data) arbiter in front of a
// single shared memory port. One transaction outstanding at a time. Data wins
// by default; fetch is forced once data has been granted STARVE_LIM times in a
// row while fetch was waiting. A BUSY phase that sees no m_ack within TIMEOUT
// cycles is aborted and reported with err on the done pulse.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter int STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                rst,
  // fetch requester
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  // data requester
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                err,
  // shared memory port
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [3:0] STARVE_C  = 4'(STARVE_LIM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic [3:0]        starve_reg, starve_next;
  logic              m_req_reg, m_req_next;
  logic              m_we_reg, m_we_next;
  logic [ADDR_W-1:0] m_addr_reg, m_addr_next;
  logic [DATA_W-1:0] m_wdata_reg, m_wdata_next;
  logic [BE_W-1:0]   m_be_reg, m_be_next;
  logic              if_done_reg, if_done_next;
  logic              d_done_reg, d_done_next;
  logic              err_reg, err_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;

  // A requester whose done pulse is currently showing still has its request
  // raised; it must not be granted again on that stale request.
  logic fetch_elig, data_elig, starved, fetch_win, finish, rdata_sel_ack;
  logic [DATA_W-1:0] done_data;

  assign fetch_elig    = if_req & ~if_done_reg;
  assign data_elig     = d_req & ~d_done_reg;
  assign starved       = (starve_reg == STARVE_C);
  assign fetch_win     = fetch_elig & (~data_elig | starved);
  // An ack landing on the timeout cycle still counts as a normal completion.
  assign finish        = m_ack | (cnt_reg == TIMEOUT_C);
  assign rdata_sel_ack = m_ack;
  assign done_data     = rdata_sel_ack ? m_rdata : '0;

  // Next-state, arbitration and output computation.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    starve_next   = starve_reg;
    m_req_next    = m_req_reg;
    m_we_next     = m_we_reg;
    m_addr_next   = m_addr_reg;
    m_wdata_next  = m_wdata_reg;
    m_be_next     = m_be_reg;
    if_done_next  = 1'b0;
    d_done_next   = 1'b0;
    err_next      = 1'b0;
    if_rdata_next = if_rdata_reg;
    d_rdata_next  = d_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (fetch_win) begin
          state_next   = BUSY_I;
          cnt_next     = 8'd1;
          starve_next  = 4'd0;
          m_req_next   = 1'b1;
          m_we_next    = 1'b0;
          m_addr_next  = if_addr;
          m_wdata_next = '0;
          m_be_next    = '1;
        end else if (data_elig) begin
          state_next   = BUSY_D;
          cnt_next     = 8'd1;
          m_req_next   = 1'b1;
          m_we_next    = d_we;
          m_addr_next  = d_addr;
          m_wdata_next = d_wdata;
          m_be_next    = d_be;
          if (if_req && !starved) begin
            starve_next = starve_reg + 4'd1;
          end
        end
      end

      BUSY_I, BUSY_D: begin
        if (finish) begin
          state_next = IDLE;
          m_req_next = 1'b0;
          err_next   = ~m_ack;
          if (state_reg == BUSY_I) begin
            if_done_next  = 1'b1;
            if_rdata_next = done_data;
          end else begin
            d_done_next  = 1'b1;
            d_rdata_next = done_data;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
        m_req_next = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything and drops any
  // transaction in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 8'd0;
      starve_reg   <= 4'd0;
      m_req_reg    <= 1'b0;
      m_we_reg     <= 1'b0;
      m_addr_reg   <= '0;
      m_wdata_reg  <= '0;
      m_be_reg     <= '0;
      if_done_reg  <= 1'b0;
      d_done_reg   <= 1'b0;
      err_reg      <= 1'b0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      starve_reg   <= starve_next;
      m_req_reg    <= m_req_next;
      m_we_reg     <= m_we_next;
      m_addr_reg   <= m_addr_next;
      m_wdata_reg  <= m_wdata_next;
      m_be_reg     <= m_be_next;
      if_done_reg  <= if_done_next;
      d_done_reg   <= d_done_next;
      err_reg      <= err_next;
      if_rdata_reg <= if_rdata_next;
      d_rdata_reg  <= d_rdata_next;
    end
  end

  assign if_done  = if_done_reg;
  assign if_rdata = if_rdata_reg;
  assign d_done   = d_done_reg;
  assign d_rdata  = d_rdata_reg;
  assign err      = err_reg;
  assign m_req    = m_req_reg;
  assign m_we     = m_we_reg;
  assign m_addr   = m_addr_reg;
  assign m_wdata  = m_wdata_reg;
  assign m_be     = m_be_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a table of directed cycles, hand-written corner
// sequences (starvation, timeout, reset mid-transaction) and a randomized run,
// all checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TIMEOUT    = 255;
  localparam int STARVE_LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ack;
  logic [31:0] m_rdata;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // owner: 0 = nobody holds the memory, 1 = fetch, 2 = data
  int          owner = 0;
  int          age = 0;        // BUSY cycles spent so far on this transaction
  int          starve = 0;     // data grants in a row while fetch waited
  logic        e_mreq = 0, e_mwe = 0;
  logic [31:0] e_maddr = 0, e_mwdata = 0;
  logic [3:0]  e_mbe = 0;
  logic        e_if_done = 0, e_d_done = 0, e_err = 0;
  logic [31:0] e_if_rdata = 0, e_d_rdata = 0;

  task automatic model_edge();
    bit f_ok, d_ok;
    logic [31:0] v;
    if (rst) begin
      owner = 0; age = 0; starve = 0;
      e_mreq = 0; e_mwe = 0; e_maddr = 0; e_mwdata = 0; e_mbe = 0;
      e_if_done = 0; e_d_done = 0; e_err = 0; e_if_rdata = 0; e_d_rdata = 0;
      return;
    end
    f_ok = if_req && !e_if_done;
    d_ok = d_req && !e_d_done;
    e_if_done = 0; e_d_done = 0; e_err = 0;
    if (owner == 0) begin
      if (f_ok && (!d_ok || starve == STARVE_LIM)) begin
        owner = 1; age = 1; starve = 0;
        e_mreq = 1; e_mwe = 0; e_maddr = if_addr; e_mwdata = 0; e_mbe = 4'hF;
      end else if (d_ok) begin
        owner = 2; age = 1;
        if (if_req) starve = (starve + 1 > STARVE_LIM) ? STARVE_LIM : starve + 1;
        e_mreq = 1; e_mwe = d_we; e_maddr = d_addr; e_mwdata = d_wdata; e_mbe = d_be;
      end
    end else if (m_ack || age >= TIMEOUT) begin
      v = m_ack ? m_rdata : 32'h0;
      if (owner == 1) begin e_if_done = 1; e_if_rdata = v; end
      else begin e_d_done = 1; e_d_rdata = v; end
      e_err = !m_ack;
      $display("txn %s addr=%h we=%b rdata=%h err=%b", (owner == 1) ? "fetch" : "data ",
               e_maddr, e_mwe, v, !m_ack);
      owner = 0;
      e_mreq = 0;
    end else begin
      age++;
    end
  endtask

  // One clock: model advances on the edge, DUT outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("m_req", m_req, e_mreq);
    if (e_mreq) begin
      check("m_we", m_we, e_mwe);
      check("m_addr", m_addr, e_maddr);
      check("m_wdata", m_wdata, e_mwdata);
      check("m_be", m_be, e_mbe);
    end
    check("if_done", if_done, e_if_done);
    check("d_done", d_done, e_d_done);
    check("err", err, e_err);
    if (e_if_done) check("if_rdata", if_rdata, e_if_rdata);
    if (e_d_done)  check("d_rdata", d_rdata, e_d_rdata);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_req"}, m_req, 0);
    check({tag, "_m_we"}, m_we, 0);
    check({tag, "_m_addr"}, m_addr, 0);
    check({tag, "_m_wdata"}, m_wdata, 0);
    check({tag, "_m_be"}, m_be, 0);
    check({tag, "_if_done"}, if_done, 0);
    check({tag, "_d_done"}, d_done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_if_rdata"}, if_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        x_mreq;
    logic        x_mwe;
    logic [31:0] x_maddr;
    logic        x_ifd;
    logic        x_dd;
    logic [31:0] x_rdata;
  } vec_t;

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                              logic [31:0] dwd, logic ak, logic [31:0] rd, logic xm,
                              logic xw, logic [31:0] xa, logic xi, logic xd, logic [31:0] xr);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da;
    v.d_wdata = dwd; v.m_ack = ak; v.m_rdata = rd; v.x_mreq = xm; v.x_mwe = xw;
    v.x_maddr = xa; v.x_ifd = xi; v.x_dd = xd; v.x_rdata = xr;
    return v;
  endfunction

  vec_t vecs[10];

  // Starvation run: data held high, memory acks every BUSY cycle at once, fetch
  // request withdrawn only during data done cycles so data keeps winning.
  task automatic starve_run(output int ndata);
    bit got_fetch = 0;
    logic prev = 0;
    ndata = 0;
    d_req = 1; d_we = 1; d_be = 4'hF; if_req = 1; if_addr = 32'h0000_0800;
    for (int c = 0; c < 60 && !got_fetch; c++) begin
      m_ack = m_req;
      d_addr = 32'h1000 + c; d_wdata = $urandom;
      step();
      if (m_req && !prev) begin
        if (m_we) ndata++;
        else got_fetch = 1;
      end
      prev = m_req;
      if_req = !e_d_done;
    end
    check("starve_fetch_granted", got_fetch, 1);
    d_req = 0; m_ack = 1; m_rdata = 32'h5151_0000;
    step();
    check("starve_if_done", if_done, 1);
    if_req = 0; m_ack = 0;
    step();
  endtask

  initial begin
    int nd;
    int busy;
    bit seen;
    rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    d_be = 0; m_ack = 0; m_rdata = 0;
    step();
    step();
    check_all_zero("reset");
    rst = 0;
    step();

    //          if_req if_addr       d_req we d_addr        d_wdata       ack rdata          mreq we maddr       ifd dd rdata
    vecs[0] = mk(1, 32'h100, 0, 0, 32'h0,   32'h0,        0, 32'h0,        1, 0, 32'h100, 0, 0, 32'h0);
    vecs[1] = mk(1, 32'h100, 0, 0, 32'h0,   32'h0,        0, 32'h0,        1, 0, 32'h100, 0, 0, 32'h0);
    vecs[2] = mk(1, 32'h100, 0, 0, 32'h0,   32'h0,        1, 32'hDEADBEEF, 0, 0, 32'h0,   1, 0, 32'hDEADBEEF);
    vecs[3] = mk(1, 32'h100, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0, 0, 32'h0,   0, 0, 32'h0);
    vecs[4] = mk(0, 32'h100, 0, 0, 32'h0,   32'h0,        1, 32'h77,       0, 0, 32'h0,   0, 0, 32'h0);
    vecs[5] = mk(1, 32'h300, 1, 1, 32'h200, 32'h12345678, 0, 32'h0,        1, 1, 32'h200, 0, 0, 32'h0);
    vecs[6] = mk(1, 32'h300, 1, 1, 32'h200, 32'h12345678, 1, 32'h0,        0, 0, 32'h0,   0, 1, 32'h0);
    vecs[7] = mk(1, 32'h300, 1, 1, 32'h200, 32'h12345678, 0, 32'h0,        1, 0, 32'h300, 0, 0, 32'h0);
    vecs[8] = mk(1, 32'h300, 0, 0, 32'h0,   32'h0,        1, 32'hCAFEF00D, 0, 0, 32'h0,   1, 0, 32'hCAFEF00D);
    vecs[9] = mk(0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 32'h0,        0, 0, 32'h0,   0, 0, 32'h0);

    d_be = 4'hF;
    for (int i = 0; i < 10; i++) begin
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr; d_req = vecs[i].d_req;
      d_we = vecs[i].d_we; d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      m_ack = vecs[i].m_ack; m_rdata = vecs[i].m_rdata;
      step();
      check($sformatf("vec%0d_m_req", i), m_req, vecs[i].x_mreq);
      if (vecs[i].x_mreq) begin
        check($sformatf("vec%0d_m_we", i), m_we, vecs[i].x_mwe);
        check($sformatf("vec%0d_m_addr", i), m_addr, vecs[i].x_maddr);
      end
      check($sformatf("vec%0d_if_done", i), if_done, vecs[i].x_ifd);
      check($sformatf("vec%0d_d_done", i), d_done, vecs[i].x_dd);
      check($sformatf("vec%0d_err", i), err, 0);
      if (vecs[i].x_ifd) check($sformatf("vec%0d_if_rdata", i), if_rdata, vecs[i].x_rdata);
      if (vecs[i].x_mreq && vecs[i].x_mwe)
        check($sformatf("vec%0d_m_wdata", i), m_wdata, 32'h12345678);
    end

    // Starvation: four data grants, then fetch; a second run shows the count restarted.
    starve_run(nd);
    check("starve_run1_data_grants", nd, STARVE_LIM);
    starve_run(nd);
    check("starve_run2_data_grants", nd, STARVE_LIM);

    // Timeout on a data read that is never acknowledged.
    d_req = 1; d_we = 0; d_addr = 32'h0000_0A00; d_be = 4'h3; m_ack = 0; m_rdata = 32'hFFFF_FFFF;
    busy = 0; seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      step();
      if (m_req) busy++;
      if (d_done) seen = 1;
    end
    check("timeout_done_seen", seen, 1);
    check("timeout_busy_cycles", busy, TIMEOUT);
    check("timeout_err", err, 1);
    check("timeout_d_rdata", d_rdata, 0);
    check("timeout_m_req", m_req, 0);
    d_req = 0;
    step();

    // Reset while BUSY_D, then a stray ack: no done, outputs cleared.
    d_req = 1; d_we = 1; d_addr = 32'h0000_0C00; d_wdata = 32'hA5A5_A5A5; d_be = 4'hF;
    step();
    step();
    rst = 1; m_ack = 1;
    step();
    check_all_zero("midrst");
    rst = 0; d_req = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("midrst_no_d_done", d_done, 0);
    end
    m_ack = 0; if_req = 1; if_addr = 32'h0000_0444;
    step();
    check("midrst_regrant_m_req", m_req, 1);
    check("midrst_regrant_m_addr", m_addr, 32'h0000_0444);
    m_ack = 1; m_rdata = 32'h0BAD_F00D;
    step();
    check("midrst_regrant_done", if_done, 1);
    if_req = 0; m_ack = 0;
    step();

    // Randomized run: protocol-abiding requesters first, then free-running inputs.
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 599) == 0);
      m_ack = ($urandom_range(0, 2) == 0);
      m_rdata = $urandom;
      if (n >= 3000) begin
        if_req = $urandom_range(0, 1); if_addr = $urandom;
        d_req = $urandom_range(0, 1); d_we = $urandom_range(0, 1);
        d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
      end else begin
        if (if_req && e_if_done) if_req = 0;
        else if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1; if_addr = $urandom; end
        if (d_req && e_d_done) d_req = 0;
        else if (!d_req && $urandom_range(0, 2) == 0) begin
          d_req = 1; d_we = $urandom_range(0, 1); d_addr = $urandom;
          d_wdata = $urandom; d_be = 4'($urandom);
        end
      end
      step();
      check("never_both_done", if_done & d_done, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
